apb_arbiter_2to1: RTL and testbench

Two-master APB arbiter that shares one downstream APB slave bus between two upstream APB masters, for example the AHB-Lite-to-APB bridge and a debug/DMA APB master. Contention is resolved round-robin. The granted transfer is re-issued on the downstream bus with a fresh setup phase, and non-granted masters are stalled in their access phase. It sits between the bridge output(s) and the APB peripheral splitter.

---
 rtl/apb_arbiter_2to1_pkg.sv | 14 +
 rtl/apb_arbiter_2to1_timeout.sv | 40 ++++
 rtl/apb_arbiter_2to1.sv | 170 +++++++++++++++++
 tb/tb_apb_arbiter_2to1.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arbiter_2to1_pkg.sv
// Shared types and constants for the two-master APB arbiter.
// State encoding, master index width and default access timeout.
package apb_arbiter_2to1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

    localparam int W_MIDX             = 1;
    localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/apb_arbiter_2to1_timeout.sv
// Downstream access-phase watchdog: counts stalled ACCESS cycles and
// flags expiry once the count reaches TIMEOUT_CYCLES.
module apb_arb_timeout
    import apb_arbiter_2to1_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic pready,
    output logic expired
);

    localparam int W_CNT = $clog2(TIMEOUT_CYCLES + 1);

    logic [W_CNT-1:0] cnt_q;
    logic [W_CNT-1:0] cnt_d;

    assign expired = active & (cnt_q == W_CNT'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && !pready && !expired) begin
            cnt_d = cnt_q + W_CNT'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_arbiter_2to1.sv
// Round-robin 2:1 APB arbiter re-issuing the granted transfer downstream.
// Optional access watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_arbiter_2to1
    import apb_arbiter_2to1_pkg::*;
#(
    parameter int W_PADDR        = 16,
    parameter int W_DATA         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               apbs0_psel,
    input  logic               apbs0_penable,
    input  logic               apbs0_pwrite,
    input  logic [W_PADDR-1:0] apbs0_paddr,
    input  logic [W_DATA-1:0]  apbs0_pwdata,
    output logic               apbs0_pready,
    output logic               apbs0_pslverr,
    output logic [W_DATA-1:0]  apbs0_prdata,
    input  logic               apbs1_psel,
    input  logic               apbs1_penable,
    input  logic               apbs1_pwrite,
    input  logic [W_PADDR-1:0] apbs1_paddr,
    input  logic [W_DATA-1:0]  apbs1_pwdata,
    output logic               apbs1_pready,
    output logic               apbs1_pslverr,
    output logic [W_DATA-1:0]  apbs1_prdata,
    output logic               apbm_psel,
    output logic               apbm_penable,
    output logic               apbm_pwrite,
    output logic [W_PADDR-1:0] apbm_paddr,
    output logic [W_DATA-1:0]  apbm_pwdata,
    input  logic               apbm_pready,
    input  logic               apbm_pslverr,
    input  logic [W_DATA-1:0]  apbm_prdata
);

    arb_state_e         state_q, state_d;
    logic [W_MIDX-1:0]  gnt_q, gnt_d;
    logic [W_MIDX-1:0]  last_q, last_d;
    logic [W_PADDR-1:0] paddr_q, paddr_d;
    logic               pwrite_q, pwrite_d;
    logic [W_DATA-1:0]  pwdata_q, pwdata_d;

    logic [1:0]         req;
    logic [W_MIDX-1:0]  peer;
    logic [W_MIDX-1:0]  load_idx;
    logic               load;
    logic               in_access;
    logic               expired;
    logic               ack;
    logic               err;
    logic               done;
    logic               sel0;
    logic               sel1;

    // penable is irrelevant: a master counts as requesting on psel alone
    logic unused_penable;
    assign unused_penable = apbs0_penable ^ apbs1_penable;

    assign req       = {apbs1_psel, apbs0_psel};
    assign peer      = ~gnt_q;
    assign in_access = (state_q == ST_ACCESS);
    assign ack       = apbm_pready | expired;
    assign err       = apbm_pready ? apbm_pslverr : expired;
    assign done      = in_access & ack;

`ifdef APB_ARB_TIMEOUT_EN
    apb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_q == ST_SETUP),
        .active  (in_access),
        .pready  (apbm_pready),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        load     = 1'b0;
        load_idx = gnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    load     = 1'b1;
                    load_idx = (&req) ? ~last_q : W_MIDX'(req[1]);
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // the completing master's own psel is deliberately not looked at
                if (done) begin
                    last_d = gnt_q;
                    if (req[peer]) begin
                        load     = 1'b1;
                        load_idx = peer;
                        state_d  = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load) begin
            gnt_d = load_idx;
            if (load_idx != '0) begin
                paddr_d  = apbs1_paddr;
                pwrite_d = apbs1_pwrite;
                pwdata_d = apbs1_pwdata;
            end else begin
                paddr_d  = apbs0_paddr;
                pwrite_d = apbs0_pwrite;
                pwdata_d = apbs0_pwdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            last_q   <= W_MIDX'(1);
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
        end
    end

    assign apbm_psel    = (state_q != ST_IDLE);
    assign apbm_penable = in_access;
    assign apbm_paddr   = paddr_q;
    assign apbm_pwrite  = pwrite_q;
    assign apbm_pwdata  = pwdata_q;

    assign sel0 = in_access & (gnt_q == '0);
    assign sel1 = in_access & (gnt_q != '0);

    assign apbs0_pready  = sel0 & ack;
    assign apbs0_pslverr = sel0 & err;
    assign apbs1_pready  = sel1 & ack;
    assign apbs1_pslverr = sel1 & err;
    assign apbs0_prdata  = apbm_prdata;
    assign apbs1_prdata  = apbm_prdata;

endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// Directed table-driven bench for apb_arbiter_2to1.
// Define APB_ARB_TIMEOUT_EN to also exercise the access watchdog.
module tb_apb_arbiter_2to1;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 255;
`endif

    typedef struct packed {
        logic        sel;
        logic        en;
        logic        wr;
        logic [15:0] a;
        logic [31:0] d;
    } up_t;

    typedef struct {
        logic        rst;
        up_t         s0;
        up_t         s1;
        logic        rdy;
        logic        err;
        logic [31:0] rd;
        up_t         em;
        logic [3:0]  es;
    } vec_t;

    localparam up_t Z = '0;

    logic        clk;
    logic        rst_n;
    logic        apbs0_psel, apbs0_penable, apbs0_pwrite;
    logic [15:0] apbs0_paddr;
    logic [31:0] apbs0_pwdata;
    logic        apbs0_pready, apbs0_pslverr;
    logic [31:0] apbs0_prdata;
    logic        apbs1_psel, apbs1_penable, apbs1_pwrite;
    logic [15:0] apbs1_paddr;
    logic [31:0] apbs1_pwdata;
    logic        apbs1_pready, apbs1_pslverr;
    logic [31:0] apbs1_prdata;
    logic        apbm_psel, apbm_penable, apbm_pwrite;
    logic [15:0] apbm_paddr;
    logic [31:0] apbm_pwdata;
    logic        apbm_pready, apbm_pslverr;
    logic [31:0] apbm_prdata;

    int checks;
    int failures;
    int step;
    vec_t tbl[$];

    apb_arbiter_2to1 #(
        .W_PADDR(16),
        .W_DATA(32),
        .TIMEOUT_CYCLES(TB_TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .apbs0_psel(apbs0_psel),
        .apbs0_penable(apbs0_penable),
        .apbs0_pwrite(apbs0_pwrite),
        .apbs0_paddr(apbs0_paddr),
        .apbs0_pwdata(apbs0_pwdata),
        .apbs0_pready(apbs0_pready),
        .apbs0_pslverr(apbs0_pslverr),
        .apbs0_prdata(apbs0_prdata),
        .apbs1_psel(apbs1_psel),
        .apbs1_penable(apbs1_penable),
        .apbs1_pwrite(apbs1_pwrite),
        .apbs1_paddr(apbs1_paddr),
        .apbs1_pwdata(apbs1_pwdata),
        .apbs1_pready(apbs1_pready),
        .apbs1_pslverr(apbs1_pslverr),
        .apbs1_prdata(apbs1_prdata),
        .apbm_psel(apbm_psel),
        .apbm_penable(apbm_penable),
        .apbm_pwrite(apbm_pwrite),
        .apbm_paddr(apbm_paddr),
        .apbm_pwdata(apbm_pwdata),
        .apbm_pready(apbm_pready),
        .apbm_pslverr(apbm_pslverr),
        .apbm_prdata(apbm_prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic up_t u(int sel, int en, int wr, int a, int d);
        up_t r;
        r.sel = sel[0];
        r.en  = en[0];
        r.wr  = wr[0];
        r.a   = a[15:0];
        r.d   = d;
        return r;
    endfunction

    function automatic vec_t mk(int r, up_t s0, up_t s1, int rdy, int err,
                                int rd, up_t em, int es);
        vec_t v;
        v.rst = r[0];
        v.s0  = s0;
        v.s1  = s1;
        v.rdy = rdy[0];
        v.err = err[0];
        v.rd  = rd;
        v.em  = em;
        v.es  = es[3:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, step, act, exp);
        end
    endtask

    task automatic cyc(input vec_t v);
        rst_n         = v.rst;
        apbs0_psel    = v.s0.sel;
        apbs0_penable = v.s0.en;
        apbs0_pwrite  = v.s0.wr;
        apbs0_paddr   = v.s0.a;
        apbs0_pwdata  = v.s0.d;
        apbs1_psel    = v.s1.sel;
        apbs1_penable = v.s1.en;
        apbs1_pwrite  = v.s1.wr;
        apbs1_paddr   = v.s1.a;
        apbs1_pwdata  = v.s1.d;
        apbm_pready   = v.rdy;
        apbm_pslverr  = v.err;
        apbm_prdata   = v.rd;
        @(negedge clk);
        chk("m_psel", 32'(apbm_psel), 32'(v.em.sel));
        chk("m_penable", 32'(apbm_penable), 32'(v.em.en));
        if (v.em.sel || !v.rst) begin
            chk("m_pwrite", 32'(apbm_pwrite), 32'(v.em.wr));
            chk("m_paddr", 32'(apbm_paddr), 32'(v.em.a));
            chk("m_pwdata", apbm_pwdata, v.em.d);
        end
        chk("s0_pready", 32'(apbs0_pready), 32'(v.es[3]));
        chk("s0_pslverr", 32'(apbs0_pslverr), 32'(v.es[2]));
        chk("s1_pready", 32'(apbs1_pready), 32'(v.es[1]));
        chk("s1_pslverr", 32'(apbs1_pslverr), 32'(v.es[0]));
        chk("s0_prdata", apbs0_prdata, v.rd);
        chk("s1_prdata", apbs1_prdata, v.rd);
        step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        step     = 0;
        rst_n    = 1'b0;
        {apbs0_psel, apbs0_penable, apbs0_pwrite} = 3'b000;
        {apbs1_psel, apbs1_penable, apbs1_pwrite} = 3'b000;
        apbs0_paddr  = '0;
        apbs0_pwdata = '0;
        apbs1_paddr  = '0;
        apbs1_pwdata = '0;
        apbm_pready  = 1'b0;
        apbm_pslverr = 1'b0;
        apbm_prdata  = '0;

        // reset state, with slave driving ready/error
        tbl.push_back(mk(0, Z, Z, 1, 1, 0, Z, 0));
        // simultaneous reads after reset: master 0 first, master 1 two later
        tbl.push_back(mk(1, u(1,0,0,'h100,0), u(1,0,0,'h200,0), 1,0,0, Z, 0));
        tbl.push_back(mk(1, u(1,1,0,'h100,0), u(1,1,0,'h200,0), 1,0,0,
                         u(1,0,0,'h100,0), 0));
        tbl.push_back(mk(1, u(1,1,0,'h100,0), u(1,1,0,'h200,0), 1,0,'h11,
                         u(1,1,0,'h100,0), 'b1000));
        tbl.push_back(mk(1, Z, u(1,1,0,'h200,0), 1,0,'h22,
                         u(1,0,0,'h200,0), 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h200,0), 1,0,'h22,
                         u(1,1,0,'h200,0), 'b0010));
        tbl.push_back(mk(1, Z, Z, 1,0,0, Z, 0));
        // master 0 write, zero-wait slave
        tbl.push_back(mk(1, u(1,0,1,'h10,'hDEADBEEF), Z, 1,0,0, Z, 0));
        tbl.push_back(mk(1, u(1,1,1,'h10,'hDEADBEEF), Z, 1,0,0,
                         u(1,0,1,'h10,'hDEADBEEF), 0));
        tbl.push_back(mk(1, u(1,1,1,'h10,'hDEADBEEF), Z, 1,0,0,
                         u(1,1,1,'h10,'hDEADBEEF), 'b1000));
        tbl.push_back(mk(1, Z, Z, 1,0,0, Z, 0));
        // back-to-back alternation 0,1,0,1,0
        tbl.push_back(mk(1, u(1,0,1,'hA00,'hA0), Z, 1,0,0, Z, 0));
        tbl.push_back(mk(1, u(1,1,1,'hA00,'hA0), u(1,0,1,'hB00,'hB0), 1,0,0,
                         u(1,0,1,'hA00,'hA0), 0));
        tbl.push_back(mk(1, u(1,1,1,'hA00,'hA0), u(1,1,1,'hB00,'hB0), 1,0,0,
                         u(1,1,1,'hA00,'hA0), 'b1000));
        tbl.push_back(mk(1, u(1,0,1,'hA04,'hA1), u(1,1,1,'hB00,'hB0), 1,0,0,
                         u(1,0,1,'hB00,'hB0), 0));
        tbl.push_back(mk(1, u(1,1,1,'hA04,'hA1), u(1,1,1,'hB00,'hB0), 1,0,0,
                         u(1,1,1,'hB00,'hB0), 'b0010));
        tbl.push_back(mk(1, u(1,1,1,'hA04,'hA1), u(1,0,1,'hB04,'hB1), 1,0,0,
                         u(1,0,1,'hA04,'hA1), 0));
        tbl.push_back(mk(1, u(1,1,1,'hA04,'hA1), u(1,1,1,'hB04,'hB1), 1,0,0,
                         u(1,1,1,'hA04,'hA1), 'b1000));
        tbl.push_back(mk(1, u(1,0,1,'hA08,'hA2), u(1,1,1,'hB04,'hB1), 1,0,0,
                         u(1,0,1,'hB04,'hB1), 0));
        tbl.push_back(mk(1, u(1,1,1,'hA08,'hA2), u(1,1,1,'hB04,'hB1), 1,0,0,
                         u(1,1,1,'hB04,'hB1), 'b0010));
        tbl.push_back(mk(1, u(1,1,1,'hA08,'hA2), Z, 1,0,0,
                         u(1,0,1,'hA08,'hA2), 0));
        tbl.push_back(mk(1, u(1,1,1,'hA08,'hA2), Z, 1,0,0,
                         u(1,1,1,'hA08,'hA2), 'b1000));
        tbl.push_back(mk(1, Z, Z, 1,0,0, Z, 0));
        // three wait states, error on completion
        tbl.push_back(mk(1, Z, u(1,0,0,'h300,0), 0,0,0, Z, 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h300,0), 0,0,0,
                         u(1,0,0,'h300,0), 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h300,0), 0,1,0,
                         u(1,1,0,'h300,0), 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h300,0), 0,0,0,
                         u(1,1,0,'h300,0), 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h300,0), 0,0,0,
                         u(1,1,0,'h300,0), 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h300,0), 1,1,'h33,
                         u(1,1,0,'h300,0), 'b0011));
        tbl.push_back(mk(1, Z, Z, 1,0,0, Z, 0));
        // leave last=0, then reset during master 1 ACCESS
        tbl.push_back(mk(1, u(1,0,1,'h40,'h40), Z, 1,0,0, Z, 0));
        tbl.push_back(mk(1, u(1,1,1,'h40,'h40), Z, 1,0,0,
                         u(1,0,1,'h40,'h40), 0));
        tbl.push_back(mk(1, u(1,1,1,'h40,'h40), Z, 1,0,0,
                         u(1,1,1,'h40,'h40), 'b1000));
        tbl.push_back(mk(1, Z, u(1,0,0,'h50,0), 0,0,0, Z, 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h50,0), 0,0,0,
                         u(1,0,0,'h50,0), 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h50,0), 0,0,0,
                         u(1,1,0,'h50,0), 0));
        tbl.push_back(mk(0, Z, u(1,1,0,'h50,0), 1,1,0, Z, 0));
        tbl.push_back(mk(1, u(1,0,0,'h60,0), u(1,0,0,'h70,0), 1,0,0, Z, 0));
        tbl.push_back(mk(1, u(1,1,0,'h60,0), u(1,1,0,'h70,0), 1,0,0,
                         u(1,0,0,'h60,0), 0));
        tbl.push_back(mk(1, u(1,1,0,'h60,0), u(1,1,0,'h70,0), 1,0,'h66,
                         u(1,1,0,'h60,0), 'b1000));
        tbl.push_back(mk(1, Z, u(1,1,0,'h70,0), 1,0,'h77,
                         u(1,0,0,'h70,0), 0));
        tbl.push_back(mk(1, Z, u(1,1,0,'h70,0), 1,0,'h77,
                         u(1,1,0,'h70,0), 'b0010));
        tbl.push_back(mk(1, Z, Z, 1,0,0, Z, 0));

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i]) cyc(tbl[i]);

        // downstream fields hold while the upstream master wiggles its bus
        cyc(mk(1, u(1,0,1,'h80,'h80), Z, 0,0,0, Z, 0));
        cyc(mk(1, u(1,1,1,'h80,'h80), Z, 0,0,0, u(1,0,1,'h80,'h80), 0));
        for (int i = 0; i < 3; i++) begin
            cyc(mk(1, u(1,1,0,'h81+i,'hF0+i), Z, (i == 2) ? 1 : 0, 0, 0,
                   u(1,1,1,'h80,'h80), (i == 2) ? 'b1000 : 0));
        end
        cyc(mk(1, Z, Z, 0,0,0, Z, 0));

`ifdef APB_ARB_TIMEOUT_EN
        // stuck slave: forced error completion, downstream abandoned
        cyc(mk(1, u(1,0,0,'h90,0), Z, 0,0,0, Z, 0));
        cyc(mk(1, u(1,1,0,'h90,0), Z, 0,0,0, u(1,0,0,'h90,0), 0));
        for (int i = 0; i < TB_TO; i++) begin
            cyc(mk(1, u(1,1,0,'h90,0), Z, 0,0,0, u(1,1,0,'h90,0), 0));
        end
        cyc(mk(1, u(1,1,0,'h90,0), Z, 0,0,0, u(1,1,0,'h90,0), 'b1100));
        cyc(mk(1, Z, Z, 0,0,0, Z, 0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
